// File: rtl/ram_if_responder.sv
// Memory-side responder for the cartridge RAM_IF port. Turns level-style OE_n/WE_n
// requests into single req/ack commands on a 16-bit memory port. Throttles the host
// with WAIT_n and schedules refresh from the host hint and from an interval timer.
module ram_if_responder #(
  parameter int unsigned REFRESH_INTERVAL = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] RAM_ADDR,
  input  logic [15:0] RAM_DIN,
  input  logic        RAM_DIN_SIZE,
  input  logic        RAM_OE_n,
  input  logic        RAM_WE_n,
  input  logic        RAM_RFSH_n,
  output logic [15:0] RAM_DOUT,
  output logic        RAM_WAIT_n,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        MEM_REF,
  output logic [22:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic [1:0]  MEM_BE,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_RDATA
);

  localparam int unsigned CntW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CntW-1:0] CntMax =
    (REFRESH_INTERVAL == 0) ? '0 : CntW'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StRefresh} state_e;

  state_e state_q, state_d;

  logic oe_q, oe_prev_q, we_q, we_prev_q, rfsh_q, rfsh_prev_q;
  logic rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d, ref_pend_q, ref_pend_d;
  logic [23:0] acc_addr_q, acc_addr_d;
  logic [15:0] acc_din_q, acc_din_d;
  logic        acc_size_q, acc_size_d;
  logic [CntW-1:0] ref_cnt_q;

  logic rd_start, wr_start, rfsh_fall, acc_busy, rd_take, wr_take;
  logic timer_exp, ref_event, ack_acc, ack_ref, issue_acc, issue_ref;
  logic [15:0] cmd_wdata;
  logic [1:0]  cmd_be;

  // Edge detection on the registered strobes; one access at a time is accepted,
  // a simultaneous read and write start keeps only the write.
  always_comb begin
    rd_start  = oe_prev_q & ~oe_q;
    wr_start  = we_prev_q & ~we_q;
    rfsh_fall = rfsh_prev_q & ~rfsh_q;
    acc_busy  = rd_pend_q | wr_pend_q;
    wr_take   = wr_start & ~acc_busy;
    rd_take   = rd_start & ~wr_start & ~acc_busy;
    // While a refresh is already pending the saturated timer must not re-arm it.
    timer_exp = (REFRESH_INTERVAL != 0) && (ref_cnt_q == CntMax) && !ref_pend_q;
    ref_event = rfsh_fall | timer_exp;
    ack_acc   = (state_q == StAccess) & MEM_ACK;
    ack_ref   = (state_q == StRefresh) & MEM_ACK;
    RAM_WAIT_n = ~acc_busy;
  end

  // Pending flags and latched access fields; a new refresh event wins over a clear.
  always_comb begin
    rd_pend_d  = rd_pend_q;
    wr_pend_d  = wr_pend_q;
    ref_pend_d = ref_pend_q;
    acc_addr_d = acc_addr_q;
    acc_din_d  = acc_din_q;
    acc_size_d = acc_size_q;
    if (ack_acc) begin
      rd_pend_d = 1'b0;
      wr_pend_d = 1'b0;
    end
    if (wr_take) begin
      wr_pend_d = 1'b1;
    end else if (rd_take) begin
      rd_pend_d = 1'b1;
    end
    if (wr_take || rd_take) begin
      acc_addr_d = RAM_ADDR;
      acc_din_d  = RAM_DIN;
      acc_size_d = RAM_DIN_SIZE;
    end
    if (ack_ref) ref_pend_d = 1'b0;
    if (ref_event) ref_pend_d = 1'b1;
  end

  // Write data / byte-enable formatting for the command about to be issued.
  always_comb begin
    cmd_wdata = acc_size_d ? acc_din_d : {acc_din_d[7:0], acc_din_d[7:0]};
    cmd_be    = acc_size_d ? 2'b11 : (acc_addr_d[0] ? 2'b10 : 2'b01);
  end

  // Next-state logic; accesses always take priority over refresh when idle.
  always_comb begin
    state_d   = state_q;
    issue_acc = 1'b0;
    issue_ref = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_pend_q || wr_pend_q || rd_take || wr_take) begin
          state_d   = StAccess;
          issue_acc = 1'b1;
        end else if (ref_pend_q || ref_event) begin
          state_d   = StRefresh;
          issue_ref = 1'b1;
        end
      end
      StAccess: begin
        if (MEM_ACK) state_d = StIdle;
      end
      StRefresh: begin
        if (MEM_ACK) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, strobe history, pending flags and latched access fields.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      oe_q        <= 1'b1;
      oe_prev_q   <= 1'b1;
      we_q        <= 1'b1;
      we_prev_q   <= 1'b1;
      rfsh_q      <= 1'b1;
      rfsh_prev_q <= 1'b1;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      ref_pend_q  <= 1'b0;
      acc_addr_q  <= '0;
      acc_din_q   <= '0;
      acc_size_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      oe_q        <= RAM_OE_n;
      oe_prev_q   <= oe_q;
      we_q        <= RAM_WE_n;
      we_prev_q   <= we_q;
      rfsh_q      <= RAM_RFSH_n;
      rfsh_prev_q <= rfsh_q;
      rd_pend_q   <= rd_pend_d;
      wr_pend_q   <= wr_pend_d;
      ref_pend_q  <= ref_pend_d;
      acc_addr_q  <= acc_addr_d;
      acc_din_q   <= acc_din_d;
      acc_size_q  <= acc_size_d;
    end
  end

  // Refresh interval timer: saturates at expiry, restarts on refresh completion.
  always_ff @(posedge CLK) begin
    if (RESET || ack_ref) begin
      ref_cnt_q <= '0;
    end else if (ref_cnt_q != CntMax) begin
      ref_cnt_q <= ref_cnt_q + 1'b1;
    end
  end

  // Command register: fields load on issue and stay frozen until the ack cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_REF   <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      MEM_BE    <= '0;
    end else if (issue_acc) begin
      MEM_REQ   <= 1'b1;
      MEM_WE    <= wr_pend_d;
      MEM_REF   <= 1'b0;
      MEM_ADDR  <= acc_addr_d[23:1];
      MEM_WDATA <= cmd_wdata;
      MEM_BE    <= cmd_be;
    end else if (issue_ref) begin
      MEM_REQ <= 1'b1;
      MEM_WE  <= 1'b0;
      MEM_REF <= 1'b1;
    end else if (ack_acc || ack_ref) begin
      MEM_REQ <= 1'b0;
    end
  end

  // Read data return; only a completed read updates the host data bus.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RAM_DOUT <= '0;
    end else if (ack_acc && rd_pend_q) begin
      if (acc_size_q) begin
        RAM_DOUT <= MEM_RDATA;
      end else begin
        RAM_DOUT <= {8'h00, acc_addr_q[0] ? MEM_RDATA[15:8] : MEM_RDATA[7:0]};
      end
    end
  end

endmodule

// File: tb/tb_ram_if_responder.sv
// Scoreboard bench for ram_if_responder: stimulus pushes expected commands and read
// data; a monitor pops and compares whenever the DUT issues a command or returns data.
module tb_ram_if_responder;

  typedef struct packed {
    logic        we;
    logic        rf;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } cmd_t;

  logic        CLK;
  logic        RESET;
  logic [23:0] RAM_ADDR;
  logic [15:0] RAM_DIN;
  logic        RAM_DIN_SIZE, RAM_OE_n, RAM_WE_n, RAM_RFSH_n;
  logic [15:0] RAM_DOUT;
  logic        RAM_WAIT_n, MEM_REQ, MEM_WE, MEM_REF;
  logic [22:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [1:0]  MEM_BE;
  logic        MEM_ACK;
  logic [15:0] MEM_RDATA;

  // Second instance with a short refresh interval and a zero-wait PHY.
  logic        t_rst, t_oe_n;
  logic [15:0] t_dout, t_wdata;
  logic        t_wait_n, t_req, t_we, t_ref;
  logic [22:0] t_addr;
  logic [1:0]  t_be;

  ram_if_responder dut (
    .CLK(CLK), .RESET(RESET), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
    .RAM_DIN_SIZE(RAM_DIN_SIZE), .RAM_OE_n(RAM_OE_n), .RAM_WE_n(RAM_WE_n),
    .RAM_RFSH_n(RAM_RFSH_n), .RAM_DOUT(RAM_DOUT), .RAM_WAIT_n(RAM_WAIT_n),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_REF(MEM_REF), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  ram_if_responder #(.REFRESH_INTERVAL(16)) dut_t (
    .CLK(CLK), .RESET(t_rst), .RAM_ADDR(24'h000300), .RAM_DIN(16'h0000),
    .RAM_DIN_SIZE(1'b1), .RAM_OE_n(t_oe_n), .RAM_WE_n(1'b1), .RAM_RFSH_n(1'b1),
    .RAM_DOUT(t_dout), .RAM_WAIT_n(t_wait_n), .MEM_REQ(t_req), .MEM_WE(t_we),
    .MEM_REF(t_ref), .MEM_ADDR(t_addr), .MEM_WDATA(t_wdata), .MEM_BE(t_be),
    .MEM_ACK(t_req), .MEM_RDATA(16'h0000)
  );

  cmd_t        exp_cmd[$];
  logic [15:0] exp_rd[$];
  int          t_cyc[$];
  logic        t_isref[$];
  int n_checks = 0;
  int n_pass = 0;
  int rd_count = 0, wr_count = 0, ref_count = 0;
  int cyc = 0;
  bit phy_auto = 1'b1;
  int phy_delay = 0;
  logic [15:0] phy_rdata = 16'h0000;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_checks++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic void push_cmd(input logic we, input logic rf, input logic [22:0] a,
                                   input logic [15:0] wd, input logic [1:0] be);
    cmd_t c;
    c.we = we; c.rf = rf; c.addr = a; c.wdata = wd; c.be = be;
    exp_cmd.push_back(c);
  endfunction

  // PHY model: acks a request phy_delay cycles after it first appears.
  initial begin : phy
    int age;
    bit acked;
    age = 0;
    acked = 1'b0;
    forever begin
      @(negedge CLK);
      if (phy_auto) begin
        if (MEM_REQ && !acked) begin
          if (age == phy_delay) begin
            MEM_ACK = 1'b1;
            MEM_RDATA = phy_rdata;
            acked = 1'b1;
          end else begin
            MEM_ACK = 1'b0;
            age++;
          end
        end else begin
          MEM_ACK = 1'b0;
          if (!MEM_REQ) begin
            acked = 1'b0;
            age = 0;
          end
        end
      end
    end
  end

  // Main-DUT monitor: new commands and completed reads are checked against the queues.
  initial begin : monitor
    logic prev_req;
    bit   chk_dout;
    cmd_t e;
    prev_req = 1'b0;
    chk_dout = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (chk_dout) begin
        chk_dout = 1'b0;
        if (exp_rd.size() == 0) flag("dout_unexpected");
        else check("read_dout", {16'h0, RAM_DOUT}, {16'h0, exp_rd.pop_front()});
      end
      if (MEM_REQ && !prev_req) begin
        if (MEM_REF) ref_count++;
        else if (MEM_WE) wr_count++;
        else rd_count++;
        if (exp_cmd.size() == 0) begin
          flag("cmd_unexpected");
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_we", {31'h0, MEM_WE}, {31'h0, e.we});
          check("cmd_ref", {31'h0, MEM_REF}, {31'h0, e.rf});
          if (!e.rf) check("cmd_addr", {9'h0, MEM_ADDR}, {9'h0, e.addr});
          if (e.we) begin
            check("cmd_wdata", {16'h0, MEM_WDATA}, {16'h0, e.wdata});
            check("cmd_be", {30'h0, MEM_BE}, {30'h0, e.be});
          end
        end
      end
      if (MEM_REQ && MEM_ACK && !MEM_REF && !MEM_WE) chk_dout = 1'b1;
      prev_req = MEM_REQ;
    end
  end

  // Timer-DUT monitor: log the cycle and kind of each new command.
  initial begin : tmon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (t_req && !prev) begin
        t_cyc.push_back(cyc);
        t_isref.push_back(t_ref);
      end
      prev = t_req;
    end
  end

  task automatic run_access(input logic we, input logic [23:0] addr, input logic [15:0] din,
                            input logic size, input int delay, input logic [15:0] rdata,
                            output int low_cycles, output int done_at);
    @(negedge CLK);
    phy_delay = delay;
    phy_rdata = rdata;
    RAM_ADDR = addr;
    RAM_DIN = din;
    RAM_DIN_SIZE = size;
    if (we) RAM_WE_n = 1'b0;
    else RAM_OE_n = 1'b0;
    low_cycles = 0;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      #2;
      if (!RAM_WAIT_n) low_cycles++;
      else if (low_cycles > 0) begin
        done_at = k;
        break;
      end
    end
    @(negedge CLK);
    RAM_OE_n = 1'b1;
    RAM_WE_n = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic do_write(input string name, input logic [23:0] addr, input logic [15:0] din,
                          input logic size, input int delay, input logic [22:0] ea,
                          input logic [15:0] ewd, input logic [1:0] ebe);
    int low, done;
    push_cmd(1'b1, 1'b0, ea, ewd, ebe);
    run_access(1'b1, addr, din, size, delay, 16'h0, low, done);
    check({name, "_wait_low"}, low, delay + 1);
    check({name, "_wait_done"}, done, delay + 3);
  endtask

  task automatic do_read(input string name, input logic [23:0] addr, input logic size,
                         input int delay, input logic [15:0] rdata, input logic [22:0] ea,
                         input logic [15:0] edout);
    int low, done;
    push_cmd(1'b0, 1'b0, ea, 16'h0, 2'b00);
    exp_rd.push_back(edout);
    run_access(1'b0, addr, 16'h0, size, delay, rdata, low, done);
    check({name, "_wait_low"}, low, delay + 1);
    check({name, "_wait_done"}, done, delay + 3);
  endtask

  initial begin : stim
    int low, done, first, n0, n1, r0, R, guard;
    RESET = 1'b1; t_rst = 1'b1;
    RAM_ADDR = '0; RAM_DIN = '0; RAM_DIN_SIZE = 1'b0;
    RAM_OE_n = 1'b1; RAM_WE_n = 1'b1; RAM_RFSH_n = 1'b1;
    MEM_ACK = 1'b0; MEM_RDATA = '0; t_oe_n = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    check("rst_req", {31'h0, MEM_REQ}, 0);
    check("rst_we", {31'h0, MEM_WE}, 0);
    check("rst_ref", {31'h0, MEM_REF}, 0);
    check("rst_addr", {9'h0, MEM_ADDR}, 0);
    check("rst_wdata", {16'h0, MEM_WDATA}, 0);
    check("rst_be", {30'h0, MEM_BE}, 0);
    check("rst_dout", {16'h0, RAM_DOUT}, 0);
    check("rst_wait", {31'h0, RAM_WAIT_n}, 1);
    @(negedge CLK);
    RESET = 1'b0; t_rst = 1'b0;
    repeat (2) @(negedge CLK);

    do_read("rd8_odd", 24'h000123, 1'b0, 0, 16'hA55A, 23'h000091, 16'h00A5);
    do_write("wr8_even", 24'h000010, 16'h123C, 1'b0, 0, 23'h000008, 16'h3C3C, 2'b01);
    do_write("wr8_odd", 24'h000011, 16'h0077, 1'b0, 3, 23'h000008, 16'h7777, 2'b10);
    do_write("wr16_even", 24'h000020, 16'hBEEF, 1'b1, 0, 23'h000010, 16'hBEEF, 2'b11);
    do_write("wr16_odd", 24'h000021, 16'hCAFE, 1'b1, 1, 23'h000010, 16'hCAFE, 2'b11);
    #2 check("dout_hold_after_writes", {16'h0, RAM_DOUT}, 32'h00A5);
    do_read("rd16", 24'h000040, 1'b1, 2, 16'h1234, 23'h000020, 16'h1234);
    do_read("rd8_even", 24'h000042, 1'b0, 0, 16'hCDEF, 23'h000021, 16'h00EF);

    // Held request: one access only.
    push_cmd(1'b0, 1'b0, 23'h000080, 16'h0, 2'b00);
    exp_rd.push_back(16'h5566);
    n0 = rd_count;
    @(negedge CLK);
    phy_delay = 0; phy_rdata = 16'h5566;
    RAM_ADDR = 24'h000100; RAM_DIN_SIZE = 1'b1; RAM_OE_n = 1'b0;
    low = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      #2;
      if (!RAM_WAIT_n) low++;
    end
    check("held_reqs", rd_count - n0, 1);
    check("held_wait_low", low, 1);
    check("held_wait_end", {31'h0, RAM_WAIT_n}, 1);
    @(negedge CLK);
    RAM_OE_n = 1'b1;
    repeat (2) @(negedge CLK);

    // Read arriving one cycle behind a host refresh, slow PHY.
    push_cmd(1'b0, 1'b1, 23'h0, 16'h0, 2'b00);
    push_cmd(1'b0, 1'b0, 23'h000100, 16'h0, 2'b00);
    exp_rd.push_back(16'h0F0F);
    n0 = rd_count; r0 = ref_count;
    @(negedge CLK);
    phy_delay = 5; phy_rdata = 16'h0F0F;
    RAM_RFSH_n = 1'b0;
    @(negedge CLK);
    RAM_ADDR = 24'h000200; RAM_DIN_SIZE = 1'b1; RAM_OE_n = 1'b0;
    low = 0; first = -1; done = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge CLK);
      #2;
      if (!RAM_WAIT_n) begin
        if (first < 0) first = k;
        low++;
      end else if (low > 0) begin
        done = k;
        break;
      end
    end
    check("defer_wait_first", first, 3);
    check("defer_wait_low", low, 12);
    check("defer_wait_done", done, 15);
    check("defer_refs", ref_count - r0, 1);
    check("defer_reads", rd_count - n0, 1);
    @(negedge CLK);
    RAM_RFSH_n = 1'b1; RAM_OE_n = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset in the middle of a read; a late ack must be ignored.
    phy_auto = 1'b0;
    MEM_ACK = 1'b0;
    push_cmd(1'b0, 1'b0, 23'h000040, 16'h0, 2'b00);
    @(negedge CLK);
    RAM_ADDR = 24'h000080; RAM_DIN_SIZE = 1'b1; RAM_OE_n = 1'b0;
    repeat (3) @(negedge CLK);
    #2 check("rstmid_req_before", {31'h0, MEM_REQ}, 1);
    RESET = 1'b1; RAM_OE_n = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #2;
    check("rstmid_req_after", {31'h0, MEM_REQ}, 0);
    check("rstmid_wait_after", {31'h0, RAM_WAIT_n}, 1);
    @(negedge CLK);
    MEM_ACK = 1'b1; MEM_RDATA = 16'hDEAD;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    check("rstmid_dout", {16'h0, RAM_DOUT}, 0);
    check("rstmid_req_idle", {31'h0, MEM_REQ}, 0);
    phy_auto = 1'b1;

    // Timer-driven refresh period on the short-interval instance.
    check("timer_log_len", {31'h0, t_cyc.size() >= 5}, 1);
    for (int i = 1; i <= 4; i++) begin
      if (i < t_cyc.size()) begin
        check("timer_gap", t_cyc[i] - t_cyc[i-1], 17);
        check("timer_is_ref", {31'h0, t_isref[i]}, 1);
      end
    end

    // Access detected in the same cycle the timer expires: access goes first.
    n0 = t_cyc.size();
    guard = 0;
    while (t_cyc.size() == n0 && guard < 40) begin
      @(negedge CLK);
      #3;
      guard++;
    end
    if (t_cyc.size() == n0) begin
      flag("timer_no_refresh");
    end else begin
      R = t_cyc[t_cyc.size()-1];
      n1 = t_cyc.size();
      guard = 0;
      while (cyc != R + 15 && guard < 40) begin
        @(negedge CLK);
        guard++;
      end
      t_oe_n = 1'b0;
      repeat (8) @(negedge CLK);
      t_oe_n = 1'b1;
      #3;
      if (t_cyc.size() < n1 + 2) begin
        flag("collide_cmds");
      end else begin
        check("collide_first_cyc", t_cyc[n1], R + 17);
        check("collide_first_is_read", {31'h0, t_isref[n1]}, 0);
        check("collide_second_cyc", t_cyc[n1+1], R + 19);
        check("collide_second_is_ref", {31'h0, t_isref[n1+1]}, 1);
      end
    end

    repeat (4) @(negedge CLK);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
